rf_multiport: RTL and testbench

RF_MULTIPORT -- requirements
Module: rf_multiport

---
 rtl/rf_multiport.sv | 119 +++++++++++
 tb/tb_rf_multiport.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// Multi-port register file: NREAD combinational read ports, one write port, self-clearing array.
// Latency: reads 0 cycles, writes visible next cycle; clear sequence runs DEPTH cycles.
// Backpressure: none; writes during busy_o are discarded and flagged one cycle later on wr_drop_o.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module rf_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    write_enable_i,
  input  logic [ADDR_W-1:0]       write_addr_i,
  input  logic [DATA_W-1:0]       write_data_i,
  input  logic [NREAD*ADDR_W-1:0] read_addr_i,
  output logic [NREAD*DATA_W-1:0] read_data_o,
  output logic                    busy_o,
  output logic                    wr_drop_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              wr_drop_q;
  logic              busy;
  logic [DATA_W-1:0] mem [DEPTH];

  // busy comes straight from the state register, so clear_i never reaches it combinationally
  assign busy      = (state_q == CLEAR);
  assign busy_o    = busy;
  assign wr_drop_o = wr_drop_q;

  // Next-state logic: start a sweep from IDLE, walk one entry per cycle, stop after the last index
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        // clear_i is ignored here; the sweep only ends at the all-ones index, never wraps
        if (clr_cnt_q == '1) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // State, sweep counter and drop flag; reset launches a fresh sweep from index 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_drop_q <= write_enable_i && busy;
    end
  end

  // Array update: the sweep owns the array while busy, otherwise the write port does
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (busy) begin
        mem[clr_cnt_q] <= '0;
      end else if (write_enable_i) begin
        mem[write_addr_i] <= write_data_i;
      end
    end
  end

`ifdef RF_BYPASS_EN
  logic wr_ok;
  assign wr_ok = write_enable_i && !busy;
`endif

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = read_addr_i[k*ADDR_W +: ADDR_W];

    // Read mux: array value, optional write forwarding, then zero-forcing for busy and address 0
    always_comb begin
      rd = mem[ra];
`ifdef RF_BYPASS_EN
      if (wr_ok && (ra == write_addr_i)) begin
        rd = write_data_i;
      end
`endif
      if (busy || ((ZERO_REG != 0) && (ra == '0))) begin
        rd = '0;
      end
    end

    assign read_data_o[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: default 2x32 instance plus a 4-port 64-bit instance.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
// Bypass expectations follow RF_BYPASS_EN when it is defined for the build.
module tb_rf_multiport;

  logic        clk;
  logic        rst, clear, we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic        busy, drop;

  logic         rst2, clear2, we2;
  logic [4:0]   wa2;
  logic [63:0]  wd2;
  logic [19:0]  ra2;
  logic [255:0] rd2;
  logic         busy2, drop2;

  int total = 0;
  int bad   = 0;

  rf_multiport #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .write_enable_i(we),
    .write_addr_i(wa), .write_data_i(wd), .read_addr_i(ra),
    .read_data_o(rd), .busy_o(busy), .wr_drop_o(drop)
  );

  rf_multiport #(.DATA_W(64), .ADDR_W(5), .NREAD(4), .ZERO_REG(1)) u_dut4 (
    .clk_i(clk), .rst_i(rst2), .clear_i(clear2), .write_enable_i(we2),
    .write_addr_i(wa2), .write_data_i(wd2), .read_addr_i(ra2),
    .read_data_o(rd2), .busy_o(busy2), .wr_drop_o(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    int n, drops, nz;
    logic [31:0] byp_exp;

    rst = 1'b1; clear = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = {5'd0, 5'd5};
    rst2 = 1'b1; clear2 = 1'b0; we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;

    // one reset edge, then measure the power-up sweep
    @(posedge clk);
    #1;
    rst = 1'b0; rst2 = 1'b0;
    n = 0; nz = 0; drops = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (rd != 64'd0) nz++;
      drops += int'(drop);
    end
    chk("rst_busy_len", 64'(n), 64'd32);
    chk("rst_reads_zero_during", 64'(nz), 64'd0);
    chk("rst_no_drop", 64'(drops), 64'd0);
    chk("rst_read_after", rd, 64'd0);
    chk("dut4_idle_after_rst", {63'd0, busy2}, 64'd0);

    // basic write / read on both ports
    wr(5'd7, 32'hDEAD_BEEF);
    ra = {5'd7, 5'd7};
    #1;
    chk("wr7_p0", {32'd0, rd[31:0]}, 64'hDEAD_BEEF);
    chk("wr7_p1", {32'd0, rd[63:32]}, 64'hDEAD_BEEF);
    wr(5'd0, 32'h0000_1234);
    ra = {5'd7, 5'd0};
    #1;
    chk("zero_reg_p0", {32'd0, rd[31:0]}, 64'd0);
    chk("wr7_still_p1", {32'd0, rd[63:32]}, 64'hDEAD_BEEF);

    // same-cycle write and read of address 3
`ifdef RF_BYPASS_EN
    byp_exp = 32'hA5A5_A5A5;
`else
    byp_exp = 32'h0;
`endif
    ra = {5'd3, 5'd3};
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5_A5A5;
    #1;
    chk("same_cycle_rd3", {32'd0, rd[31:0]}, {32'd0, byp_exp});
    @(negedge clk);
    we = 1'b0;
    #1;
    chk("next_cycle_rd3", {32'd0, rd[63:32]}, 64'hA5A5_A5A5);

    // fill 1..31 with their index, then clear with a write attempted during busy
    for (int a = 1; a < 32; a++) wr(5'(a), 32'(a));
    ra = {5'd31, 5'd17};
    #1;
    chk("fill_rd17", {32'd0, rd[31:0]}, 64'd17);
    chk("fill_rd31", {32'd0, rd[63:32]}, 64'd31);
    clear = 1'b1;
    #1;
    chk("busy_not_comb", {63'd0, busy}, 64'd0);
    @(negedge clk);
    clear = 1'b0;
    n = 0; drops = 0; nz = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      if (rd != 64'd0) nz++;
      drops += int'(drop);
      we = (i == 0); wa = 5'd9; wd = 32'h99;
      @(negedge clk);
    end
    we = 1'b0;
    drops += int'(drop);
    chk("clr_busy_len", 64'(n), 64'd32);
    chk("clr_drop_once", 64'(drops), 64'd1);
    chk("clr_reads_zero_during", 64'(nz), 64'd0);
    ra = {5'd9, 5'd17};
    #1;
    chk("clr_after_rd17", {32'd0, rd[31:0]}, 64'd0);
    chk("clr_after_rd9", {32'd0, rd[63:32]}, 64'd0);

    // clear together with a write, reset at sweep cycle 10, second clear ignored
    wr(5'd4, 32'h44);
    clear = 1'b1; we = 1'b1; wa = 5'd12; wd = 32'hC;
    @(negedge clk);
    clear = 1'b0; we = 1'b0;
    chk("clr_wr_busy", {63'd0, busy}, 64'd1);
    chk("clr_wr_nodrop", {63'd0, drop}, 64'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0; drops = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      n++;
      drops += int'(drop);
      clear = (i == 5);
      @(negedge clk);
    end
    clear = 1'b0;
    chk("rst_mid_busy_len", 64'(n), 64'd32);
    chk("rst_mid_no_drop", 64'(drops), 64'd0);
    ra = {5'd12, 5'd4};
    #1;
    chk("rst_mid_rd4", {32'd0, rd[31:0]}, 64'd0);
    chk("rst_mid_rd12", {32'd0, rd[63:32]}, 64'd0);

    // four-port 64-bit instance
    for (int a = 1; a <= 3; a++) begin
      we2 = 1'b1; wa2 = 5'(a); wd2 = 64'(a);
      @(negedge clk);
    end
    we2 = 1'b0;
    ra2 = {5'd1, 5'd3, 5'd2, 5'd1};
    #1;
    chk("p4_port0", rd2[0*64 +: 64], 64'h1);
    chk("p4_port1", rd2[1*64 +: 64], 64'h2);
    chk("p4_port2", rd2[2*64 +: 64], 64'h3);
    chk("p4_port3", rd2[3*64 +: 64], 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
